// File: rtl/pbuf_pkg.sv
// Shared packet-buffer definitions: pbhdr layout, header init, sizing helpers
// and the write-arbiter state encoding.
package pbuf_pkg;

  localparam int PBUF_LEN     = 12;
  localparam int PB_HDR_WORDS = 3;

  // 96-bit header, written MSB word first: {len,type,flags} {ts_type,ts_id,ts_hi} {ts_lo}
  typedef struct packed {
    logic [15:0] len;
    logic [7:0]  pb_type;
    logic [7:0]  flags;
    logic [7:0]  ts_type;
    logic [7:0]  ts_id;
    logic [47:0] ts_val;
  } pbhdr_t;

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, HDR2, DATA, COMMIT, DROP
  } pb_state_e;

  function automatic pbhdr_t pb_init(input logic [15:0] len, input logic [7:0] pb_type);
    pbhdr_t h;
    h         = '0;
    h.len     = len + 16'(PBUF_LEN);
    h.pb_type = pb_type;
    return h;
  endfunction

  function automatic logic [14:0] pb_beats(input logic [15:0] len);
    logic [16:0] t;
    t = (17'(len) + 17'd3) >> 2;
    return t[14:0];
  endfunction

  function automatic logic [16:0] pb_words(input logic [15:0] len);
    return 17'(PB_HDR_WORDS) + 17'(pb_beats(len));
  endfunction

endpackage

// File: rtl/pbuf_wr_arb_rr_arb.sv
// NPORT-wide round-robin picker; the pointer moves to the picked port only
// when the owner accepts the pick (adv_i).
module rr_arb #(
  parameter int NPORT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORT-1:0]         req_i,
  input  logic                     adv_i,
  output logic [$clog2(NPORT)-1:0] idx_o,
  output logic                     any_o
);
  localparam int PW = $clog2(NPORT);

  logic [PW-1:0] last_q;
  int            c;

  // Scan from farthest to nearest so the port right after last_q wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = NPORT; k >= 1; k--) begin
      c = (int'(last_q) + k) % NPORT;
      if (req_i[c]) begin
        idx_o = PW'(c);
        any_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_q <= PW'(NPORT - 1);
    else if (adv_i) last_q <= idx_o;
  end

endmodule

// File: rtl/pbuf_wr_arb.sv
// Round-robin packet-buffer write arbiter: header + data into a circular
// word buffer, committed pointer moves only on whole packets.
// Optional PBUF_WR_TS_EN fills ts_type/ts_id/ts_val in the header.
module pbuf_wr_arb
  import pbuf_pkg::*;
#(
  parameter int NPORT  = 2,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NPORT-1:0]    req_valid,
  input  logic [NPORT*16-1:0] req_len,
  input  logic [NPORT*8-1:0]  req_type,
  output logic [NPORT-1:0]    req_grant,
  input  logic [NPORT-1:0]    dat_valid,
  input  logic [NPORT*32-1:0] dat_data,
  output logic [NPORT-1:0]    dat_ready,
  input  logic [47:0]         ts_now,
  input  logic [ADDR_W-1:0]   rd_ptr,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [31:0]         wr_data,
  output logic [ADDR_W-1:0]   wr_ptr,
  output logic                drop
);
  localparam int          PW   = $clog2(NPORT);
  localparam logic [16:0] DMAX = 17'((1 << ADDR_W) - 1);

  pb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [PW-1:0]     port_q, port_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        type_q, type_d;
  logic [14:0]       beats_q, beats_d;
`ifdef PBUF_WR_TS_EN
  logic [47:0]       ts_q, ts_d;
  logic [7:0]        seq_q, seq_d;
`else
  logic              unused_ts;
  assign unused_ts = ^ts_now;
`endif

  logic [PW-1:0]     sel;
  logic              any_req;
  logic              adv;
  logic [15:0]       sel_len;
  logic [7:0]        sel_type;
  logic [16:0]       sel_words;
  logic [16:0]       free_w;
  logic [ADDR_W-1:0] used;
  logic              grant_d, drop_d;
  logic              port_valid;
  logic [31:0]       port_data;
  pbhdr_t            hdr;

  rr_arb #(.NPORT(NPORT)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid),
    .adv_i (adv),
    .idx_o (sel),
    .any_o (any_req)
  );

  assign sel_len    = req_len[int'(sel)*16 +: 16];
  assign sel_type   = req_type[int'(sel)*8 +: 8];
  assign sel_words  = pb_words(sel_len);
  // One word stays empty so ptr==rd means empty, never full.
  assign used       = ptr_q - rd_ptr;
  assign free_w     = DMAX - 17'(used);
  assign port_valid = dat_valid[port_q];
  assign port_data  = dat_data[int'(port_q)*32 +: 32];

  always_comb begin
    hdr = pb_init(len_q, type_q);
`ifdef PBUF_WR_TS_EN
    hdr.ts_type = 8'(port_q);
    hdr.ts_id   = seq_q;
    hdr.ts_val  = ts_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    port_d    = port_q;
    len_d     = len_q;
    type_d    = type_q;
    beats_d   = beats_q;
`ifdef PBUF_WR_TS_EN
    ts_d      = ts_q;
    seq_d     = seq_q;
`endif
    grant_d   = 1'b0;
    drop_d    = 1'b0;
    adv       = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    dat_ready = '0;
    case (state_q)
      IDLE: begin
        // Strict RR: an eligible-but-blocked port holds the arbiter.
        if (any_req) begin
          if (sel_words > DMAX) begin
            grant_d = 1'b1;
            drop_d  = 1'b1;
            adv     = 1'b1;
            port_d  = sel;
            beats_d = pb_beats(sel_len);
            state_d = DROP;
          end else if (sel_words <= free_w) begin
            grant_d = 1'b1;
            adv     = 1'b1;
            port_d  = sel;
            len_d   = sel_len;
            type_d  = sel_type;
            beats_d = pb_beats(sel_len);
`ifdef PBUF_WR_TS_EN
            ts_d    = ts_now;
`endif
            state_d = HDR0;
          end
        end
      end
      HDR0: begin
        wr_en   = 1'b1;
        wr_data = hdr[95:64];
        addr_d  = addr_q + 1'b1;
        state_d = HDR1;
      end
      HDR1: begin
        wr_en   = 1'b1;
        wr_data = hdr[63:32];
        addr_d  = addr_q + 1'b1;
        state_d = HDR2;
      end
      HDR2: begin
        wr_en   = 1'b1;
        wr_data = hdr[31:0];
        addr_d  = addr_q + 1'b1;
        state_d = (beats_q == '0) ? COMMIT : DATA;
      end
      DATA: begin
        dat_ready[port_q] = 1'b1;
        if (port_valid) begin
          wr_en   = 1'b1;
          wr_data = port_data;
          addr_d  = addr_q + 1'b1;
          beats_d = beats_q - 1'b1;
          if (beats_q == 15'd1) state_d = COMMIT;
        end
      end
      COMMIT: begin
        ptr_d   = addr_q;
`ifdef PBUF_WR_TS_EN
        seq_d   = seq_q + 1'b1;
`endif
        state_d = IDLE;
      end
      DROP: begin
        dat_ready[port_q] = 1'b1;
        if (beats_q == '0) begin
          state_d = IDLE;
        end else if (port_valid) begin
          beats_d = beats_q - 1'b1;
          if (beats_q == 15'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant/drop decode straight off req_valid, so mask them while in reset.
  always_comb begin
    req_grant = '0;
    if (grant_d && rst_n) req_grant[sel] = 1'b1;
    drop = drop_d & rst_n;
  end

  assign wr_addr = addr_q;
  assign wr_ptr  = ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ptr_q   <= '0;
      port_q  <= '0;
      len_q   <= '0;
      type_q  <= '0;
      beats_q <= '0;
`ifdef PBUF_WR_TS_EN
      ts_q    <= '0;
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      len_q   <= len_d;
      type_q  <= type_d;
      beats_q <= beats_d;
`ifdef PBUF_WR_TS_EN
      ts_q    <= ts_d;
      seq_q   <= seq_d;
`endif
    end
  end

endmodule
